bus_cycle_bridge: RTL and testbench

Sequential successor to the combinational bus-cycle converter. It captures one 8088 bus cycle (IO/MEM, RD/WR, A, D) and decodes it into a 32-bit request. The request goes out on a valid/ready channel to the downstream responders (AXI master, internal ROM/RAM/LED), and the block holds CPU READY low until the response returns or a timeout expires. It adds byte-lane steering, a wait-state handshake, a timeout, and parametrised widths, and sits between the CPU pin synchroniser and the request fabric.

---
 rtl/bus_bridge_pkg.sv | 34 +++
 rtl/bus_addr_decode.sv | 67 ++++++
 rtl/bus_cycle_bridge.sv | 175 +++++++++++++++++
 tb/tb_bus_cycle_bridge.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_bridge_pkg.sv
// Shared definitions for the 8088 bus-cycle bridge: target types, AXI address bases,
// IO port numbers, strobe encodings and the bridge FSM state type.
package bus_bridge_pkg;

  localparam logic [2:0] ADDR_TYPE_NOT_OP  = 3'd0;
  localparam logic [2:0] ADDR_TYPE_AXI     = 3'd1;
  localparam logic [2:0] ADDR_TYPE_ROM     = 3'd2;
  localparam logic [2:0] ADDR_TYPE_RAM     = 3'd3;
  localparam logic [2:0] ADDR_TYPE_LED     = 3'd4;
  localparam logic [2:0] ADDR_TYPE_UNKNOWN = 3'd7;

  localparam logic [31:0] AXI_ADDR32_DRAM_BASE  = 32'h8000_0000;
  localparam logic [31:0] AXI_ADDR32_FLASH_BASE = 32'h6000_0000;
  localparam logic [31:0] AXI_ADDR32_UART_BASE  = 32'h4060_0000;

  localparam logic [15:0] IO_PORT_UART_RX   = 16'h0000;
  localparam logic [15:0] IO_PORT_UART_TX   = 16'h0001;
  localparam logic [15:0] IO_PORT_UART_STAT = 16'h0002;
  localparam logic [15:0] IO_PORT_LED       = 16'h0080;

  // {IO, MEM, RD, WR}
  localparam logic [3:0] STROBE_IO_RD  = 4'b1010;
  localparam logic [3:0] STROBE_MEM_RD = 4'b0110;
  localparam logic [3:0] STROBE_IO_WR  = 4'b1001;
  localparam logic [3:0] STROBE_MEM_WR = 4'b0101;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRsp,
    StDone
  } bridge_state_e;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational decode of one 8088 bus cycle into target type, 32-bit address and direction.
// Memory space splits on the top address bits: DRAM, flash, internal ROM, internal RAM.
module bus_addr_decode
  import bus_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 20
) (
  input  logic                  io,
  input  logic                  mem,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] a,
  output logic [2:0]            addr_type,
  output logic [31:0]           a32,
  output logic                  is_read
);

  logic [3:0]  strobe;
  logic [15:0] port;

  assign strobe = {io, mem, rd, wr};
  assign port   = a[15:0];

  always_comb begin
    addr_type = ADDR_TYPE_NOT_OP;
    a32       = '0;
    is_read   = 1'b0;
    case (strobe)
      STROBE_IO_RD, STROBE_IO_WR: begin
        is_read = rd;
        if (port == IO_PORT_UART_RX || port == IO_PORT_UART_TX ||
            port == IO_PORT_UART_STAT) begin
          addr_type = ADDR_TYPE_AXI;
          a32       = AXI_ADDR32_UART_BASE | 32'(port);
        end else if (port == IO_PORT_LED) begin
          addr_type = ADDR_TYPE_LED;
          a32       = 32'(port);
        end else begin
          addr_type = ADDR_TYPE_UNKNOWN;
        end
      end
      STROBE_MEM_RD, STROBE_MEM_WR: begin
        is_read = rd;
        if (a[ADDR_WIDTH-1]) begin
          addr_type = ADDR_TYPE_AXI;
          a32       = AXI_ADDR32_DRAM_BASE | 32'(a[ADDR_WIDTH-2:0]);
        end else if (a[ADDR_WIDTH-2]) begin
          addr_type = ADDR_TYPE_AXI;
          a32       = AXI_ADDR32_FLASH_BASE | 32'(a[ADDR_WIDTH-3:0]);
        end else if (a[ADDR_WIDTH-3]) begin
          // ROM is read-only; a write there has no target.
          if (rd) begin
            addr_type = ADDR_TYPE_ROM;
            a32       = 32'(a[ADDR_WIDTH-4:0]);
          end else begin
            addr_type = ADDR_TYPE_UNKNOWN;
          end
        end else begin
          addr_type = ADDR_TYPE_RAM;
          a32       = 32'(a[ADDR_WIDTH-4:0]);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_cycle_bridge.sv
// Captures one 8088 bus cycle, issues it as a lane-steered request and holds CPU READY low
// until the response arrives or the wait timer expires.
module bus_cycle_bridge
  import bus_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter int unsigned DATA_BYTES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    IO,
  input  logic                    MEM,
  input  logic                    RD,
  input  logic                    WR,
  input  logic [ADDR_WIDTH-1:0]   A,
  input  logic [7:0]              D,
  output logic                    cpu_ready,
  output logic [7:0]              cpu_dout,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic [31:0]             req_addr,
  output logic [8*DATA_BYTES-1:0] req_wdata,
  output logic [DATA_BYTES-1:0]   req_wstrb,
  output logic                    req_is_read,
  output logic [2:0]              req_type,
  input  logic                    rsp_valid,
  input  logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    timeout_pulse
);

  localparam int unsigned LaneW  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

  function automatic logic [LaneW-1:0] lane_of(input logic [31:0] addr);
    if (DATA_BYTES > 1) return addr[LaneW-1:0];
    else return '0;
  endfunction

  logic [2:0]  dec_type;
  logic [31:0] dec_a32;
  logic        dec_is_read;

  bus_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_decode (
    .io       (IO),
    .mem      (MEM),
    .rd       (RD),
    .wr       (WR),
    .a        (A),
    .addr_type(dec_type),
    .a32      (dec_a32),
    .is_read  (dec_is_read)
  );

  bridge_state_e           state_q, state_d;
  logic [TimerW-1:0]       timer_q, timer_d;
  logic                    cpu_ready_q, cpu_ready_d;
  logic [7:0]              cpu_dout_q, cpu_dout_d;
  logic                    req_valid_q, req_valid_d;
  logic [31:0]             req_addr_q, req_addr_d;
  logic [8*DATA_BYTES-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_BYTES-1:0]   req_wstrb_q, req_wstrb_d;
  logic                    req_is_read_q, req_is_read_d;
  logic [2:0]              req_type_q, req_type_d;
  logic                    timeout_q, timeout_d;

  logic [LaneW-1:0]        cap_lane;
  logic [LaneW-1:0]        cur_lane;
  logic [DATA_BYTES-1:0]   cap_wstrb;
  logic [7:0]              rsp_byte;

  assign cap_lane = lane_of(dec_a32);
  assign cur_lane = lane_of(req_addr_q);
  assign rsp_byte = rsp_rdata[{cur_lane, 3'b000} +: 8];

  always_comb begin
    cap_wstrb = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      cap_wstrb[i] = !dec_is_read && (LaneW'(i) == cap_lane);
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cpu_dout_d    = cpu_dout_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    req_wstrb_d   = req_wstrb_q;
    req_is_read_d = req_is_read_q;
    req_type_d    = req_type_q;
    timeout_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dec_type != ADDR_TYPE_NOT_OP) begin
          req_addr_d    = dec_a32;
          req_type_d    = dec_type;
          req_is_read_d = dec_is_read;
          req_wstrb_d   = cap_wstrb;
          req_wdata_d   = {DATA_BYTES{D}};
          // Writes and unknown targets report 0xFF; reads overwrite it on response.
          cpu_dout_d    = 8'hFF;
          state_d       = (dec_type == ADDR_TYPE_UNKNOWN) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (req_valid_q && req_ready) begin
          timer_d = '0;
          state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
        // A response on the terminal-count cycle takes priority over the timeout.
        if (rsp_valid) begin
          if (req_is_read_q) cpu_dout_d = rsp_byte;
          state_d = StDone;
        end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
          cpu_dout_d = 8'hFF;
          timeout_d  = 1'b1;
          state_d    = StDone;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDone: begin
        if (dec_type == ADDR_TYPE_NOT_OP) state_d = StIdle;
      end
    endcase

    req_valid_d = (state_d == StIssue);
    cpu_ready_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      cpu_ready_q   <= 1'b0;
      cpu_dout_q    <= 8'hFF;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      req_wstrb_q   <= '0;
      req_is_read_q <= 1'b0;
      req_type_q    <= ADDR_TYPE_NOT_OP;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      cpu_ready_q   <= cpu_ready_d;
      cpu_dout_q    <= cpu_dout_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      req_wstrb_q   <= req_wstrb_d;
      req_is_read_q <= req_is_read_d;
      req_type_q    <= req_type_d;
      timeout_q     <= timeout_d;
    end
  end

  assign cpu_ready     = cpu_ready_q;
  assign cpu_dout      = cpu_dout_q;
  assign req_valid     = req_valid_q;
  assign req_addr      = req_addr_q;
  assign req_wdata     = req_wdata_q;
  assign req_wstrb     = req_wstrb_q;
  assign req_is_read   = req_is_read_q;
  assign req_type      = req_type_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_bus_cycle_bridge.sv
// Directed and randomized bus cycles against a behavioural memory-map and handshake model.
module tb_bus_cycle_bridge;

  localparam int AW = 20;
  localparam int DB = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic IO, MEM, RD, WR;
  logic [AW-1:0] A;
  logic [7:0] D;
  logic cpu_ready;
  logic [7:0] cpu_dout;
  logic req_valid, req_ready;
  logic [31:0] req_addr;
  logic [8*DB-1:0] req_wdata;
  logic [DB-1:0] req_wstrb;
  logic req_is_read;
  logic [2:0] req_type;
  logic rsp_valid;
  logic [8*DB-1:0] rsp_rdata;
  logic timeout_pulse;

  int checks = 0;
  int errors = 0;

  bus_cycle_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_BYTES    (DB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .IO           (IO),
    .MEM          (MEM),
    .RD           (RD),
    .WR           (WR),
    .A            (A),
    .D            (D),
    .cpu_ready    (cpu_ready),
    .cpu_dout     (cpu_dout),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .req_is_read  (req_is_read),
    .req_type     (req_type),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory/IO map model: type 0 none, 1 AXI, 2 ROM, 3 RAM, 4 LED, 7 unknown.
  function automatic void model(input logic [3:0] s, input int unsigned a,
                                output logic [2:0] t, output logic [31:0] addr,
                                output logic rd);
    int unsigned port;
    int unsigned half;
    bit is_io, is_mem;
    t = 3'd0;
    addr = 32'd0;
    is_io = (s == 4'b1010) || (s == 4'b1001);
    is_mem = (s == 4'b0110) || (s == 4'b0101);
    rd = (is_io || is_mem) && (s == 4'b1010 || s == 4'b0110);
    port = a % 65536;
    half = 1 << (AW - 1);
    if (is_io) begin
      if (port <= 2) begin
        t = 3'd1;
        addr = 32'h4060_0000 + port;
      end else if (port == 128) begin
        t = 3'd4;
        addr = 32'd128;
      end else begin
        t = 3'd7;
      end
    end else if (is_mem) begin
      if (a >= half) begin
        t = 3'd1;
        addr = 32'h8000_0000 + (a - half);
      end else if (a >= half / 2) begin
        t = 3'd1;
        addr = 32'h6000_0000 + (a - half / 2);
      end else if (a >= half / 4) begin
        if (rd) begin
          t = 3'd2;
          addr = a - half / 4;
        end else begin
          t = 3'd7;
        end
      end else begin
        t = 3'd3;
        addr = a;
      end
    end
  endfunction

  // One complete bus cycle: rsp_dly WAIT_RSP cycles pass before the response pulse.
  task automatic txn(input logic [3:0] s, input int unsigned a, input logic [7:0] d,
                     input int unsigned rdy_dly, input int unsigned rsp_dly,
                     input logic [31:0] rdata, input bit late_rsp);
    logic [2:0] t;
    logic [31:0] addr;
    logic rd;
    int unsigned lane;
    logic [3:0] exp_wstrb;
    logic [31:0] exp_wdata;
    logic [7:0] exp_dout;
    bit timed_out;
    bit fin;
    int unsigned w;

    model(s, a, t, addr, rd);
    lane = addr % 4;
    exp_wstrb = '0;
    if (!rd) exp_wstrb[lane] = 1'b1;
    exp_wdata = {4{d}};
    timed_out = (t != 3'd7) && (rsp_dly >= TO);
    exp_dout = (t == 3'd7 || timed_out) ? 8'hFF : 8'((rdata >> (8 * lane)) & 32'hFF);

    @(negedge clk);
    check("idle_ready", 64'(cpu_ready), 64'(0));
    check("idle_valid", 64'(req_valid), 64'(0));
    {IO, MEM, RD, WR} = s;
    A = a[AW-1:0];
    D = d;
    rsp_rdata = rdata;
    @(negedge clk);
    A = AW'($urandom);
    D = 8'($urandom);
    if (t == 3'd7) begin
      check("unk_ready", 64'(cpu_ready), 64'(1));
      check("unk_valid", 64'(req_valid), 64'(0));
      if (rd) check("unk_dout", 64'(cpu_dout), 64'(exp_dout));
    end else begin
      for (int unsigned i = 0; i <= rdy_dly; i++) begin
        check("iss_valid", 64'(req_valid), 64'(1));
        check("iss_addr", 64'(req_addr), 64'(addr));
        check("iss_type", 64'(req_type), 64'(t));
        check("iss_rd", 64'(req_is_read), 64'(rd));
        check("iss_wstrb", 64'(req_wstrb), 64'(exp_wstrb));
        if (!rd) check("iss_wdata", 64'(req_wdata), 64'(exp_wdata));
        check("iss_ready", 64'(cpu_ready), 64'(0));
        req_ready = (i == rdy_dly);
        @(negedge clk);
      end
      req_ready = 1'b0;
      w = 1;
      fin = 1'b0;
      while (!fin) begin
        check("wait_ready", 64'(cpu_ready), 64'(0));
        check("wait_valid", 64'(req_valid), 64'(0));
        check("wait_to", 64'(timeout_pulse), 64'(0));
        rsp_valid = (w == rsp_dly + 1);
        @(negedge clk);
        rsp_valid = 1'b0;
        fin = (w == rsp_dly + 1) || (w == TO);
        w++;
      end
      check("done_ready", 64'(cpu_ready), 64'(1));
      check("done_to", 64'(timeout_pulse), 64'(timed_out));
      if (rd) check("done_dout", 64'(cpu_dout), 64'(exp_dout));
    end
    if (late_rsp) begin
      rsp_valid = 1'b1;
      rsp_rdata = $urandom;
    end
    @(negedge clk);
    rsp_valid = 1'b0;
    check("hold_ready", 64'(cpu_ready), 64'(1));
    check("hold_to", 64'(timeout_pulse), 64'(0));
    if (rd) check("hold_dout", 64'(cpu_dout), 64'(exp_dout));
    {IO, MEM, RD, WR} = 4'b0000;
    @(negedge clk);
    check("rel_ready", 64'(cpu_ready), 64'(0));
    check("rel_valid", 64'(req_valid), 64'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 64'(cpu_ready), 64'(0));
    check({tag, "_dout"}, 64'(cpu_dout), 64'(8'hFF));
    check({tag, "_valid"}, 64'(req_valid), 64'(0));
    check({tag, "_addr"}, 64'(req_addr), 64'(0));
    check({tag, "_wdata"}, 64'(req_wdata), 64'(0));
    check({tag, "_wstrb"}, 64'(req_wstrb), 64'(0));
    check({tag, "_rd"}, 64'(req_is_read), 64'(0));
    check({tag, "_type"}, 64'(req_type), 64'(0));
    check({tag, "_to"}, 64'(timeout_pulse), 64'(0));
  endtask

  initial begin
    logic [3:0] bad_strobes [6];
    logic [3:0] s;
    int unsigned a;

    bad_strobes = '{4'b0000, 4'b1111, 4'b1110, 4'b0011, 4'b1100, 4'b1011};
    rst = 1'b1;
    {IO, MEM, RD, WR} = 4'b0000;
    A = '0;
    D = '0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;

    // DRAM read with minimum latency.
    txn(4'b0110, 32'h80004, 8'h00, 0, 0, 32'hDDCC_BBAA, 1'b0);
    // UART TX write on lane 1.
    txn(4'b1001, 32'h00001, 8'h5A, 0, 0, 32'h0, 1'b0);
    // Unmapped IO read.
    txn(4'b1010, 32'h00033, 8'h00, 0, 0, 32'h0, 1'b0);
    // Request held for 10 cycles without req_ready.
    txn(4'b0110, 32'h4_1236, 8'h00, 10, 2, 32'h1122_3344, 1'b0);
    // Timeout with a late response afterwards, then a normal cycle.
    txn(4'b0110, 32'h9_0001, 8'h00, 0, 20, 32'hCAFE_F00D, 1'b1);
    txn(4'b1010, 32'h00002, 8'h00, 1, 3, 32'h00A5_0000, 1'b0);
    // Response on the terminal-count cycle wins over the timeout.
    txn(4'b0110, 32'h0_0103, 8'h00, 0, TO - 1, 32'h7788_99AA, 1'b0);
    // LED write, ROM read, ROM write (unknown).
    txn(4'b1001, 32'h00080, 8'hC3, 0, 1, 32'h0, 1'b0);
    txn(4'b0110, 32'h2_0002, 8'h00, 0, 0, 32'h5566_7788, 1'b0);
    txn(4'b0101, 32'h2_0002, 8'h44, 0, 0, 32'h0, 1'b0);

    // Invalid strobe combinations never start a cycle.
    foreach (bad_strobes[i]) begin
      @(negedge clk);
      {IO, MEM, RD, WR} = bad_strobes[i];
      A = 20'h80000;
      repeat (2) @(negedge clk);
      check("bad_valid", 64'(req_valid), 64'(0));
      check("bad_ready", 64'(cpu_ready), 64'(0));
    end
    {IO, MEM, RD, WR} = 4'b0000;

    // Reset during WAIT_RSP, stale response, then a normal read.
    @(negedge clk);
    {IO, MEM, RD, WR} = 4'b0110;
    A = 20'h80010;
    @(negedge clk);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    {IO, MEM, RD, WR} = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("midrst");
    rsp_valid = 1'b1;
    rsp_rdata = 32'h1234_5678;
    @(negedge clk);
    rsp_valid = 1'b0;
    check("stale_ready", 64'(cpu_ready), 64'(0));
    check("stale_dout", 64'(cpu_dout), 64'(8'hFF));
    txn(4'b0110, 32'h80011, 8'h00, 0, 0, 32'hA1B2_C3D4, 1'b0);

    // Randomized cycles.
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: s = 4'b1010;
        1: s = 4'b0110;
        2: s = 4'b1001;
        default: s = 4'b0101;
      endcase
      if (s[3]) begin
        case ($urandom_range(0, 4))
          0: a = 0;
          1: a = 1;
          2: a = 2;
          3: a = 128;
          default: a = $urandom_range(0, 65535);
        endcase
        a = a + ($urandom_range(0, 15) << 16);
      end else begin
        a = $urandom_range(0, (1 << AW) - 1);
      end
      txn(s, a, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 9), $urandom,
          1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
